// File: rtl/imem_boot_loader.sv
// Boot loader: turns a little-endian byte stream into 32-bit imem writes and holds the core in
// reset until a whole image is in. Define LOADER_CHECKSUM_EN to require a trailing XOR byte.
module imem_boot_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        LEN0  = 3'd0,
        LEN1  = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [15:0] depth_w = 16'(IMEM_DEPTH);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [7:0]  csum_q, csum_d;

    logic              ready_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;
    logic [15:0]       wl_d;
    logic              done_d;
    logic              error_d;
    logic              cpu_reset_d;
    logic              hold_ready;

    logic        accept;
    logic [15:0] len_n;
    logic [15:0] wl_inc;

    // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1.
    // in_ready is registered, so the source sees it a full cycle before the transferring edge;
    // while in_ready is 0 the source must hold in_data and in_valid unchanged.
    assign accept    = in_valid & in_ready;
    assign len_n     = {in_data, len_q[7:0]};
    assign wl_inc    = words_loaded + 16'd1;
    assign state_dbg = state_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        bcnt_d     = bcnt_q;
        wbuf_d     = wbuf_q;
        csum_d     = csum_q;
        we_d       = 1'b0;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        wl_d       = words_loaded;
        hold_ready = 1'b0;

        case (state_q)
            LEN0: begin
                bcnt_d = 2'd0;
                csum_d = 8'h00;
                if (accept) begin
                    len_d   = {8'h00, in_data};
                    state_d = LEN1;
                end
            end

            LEN1: begin
                if (accept) begin
                    len_d = len_n;
                    if (len_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        state_d = DONE;
`endif
                    end else if (len_n > depth_w) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                // Without a checksum the final write cycle is spent here so the last imem_we
                // always lands one cycle before the core leaves reset.
                if (words_loaded == len_q) begin
                    state_d = DONE;
                end else if (accept) begin
                    csum_d = csum_q ^ in_data;
                    wbuf_d[{bcnt_q, 3'b000} +: 8] = in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {in_data, wbuf_q[23:0]};
                        addr_d  = ADDR_W'({words_loaded, 2'b00});
                        wl_d    = wl_inc;
                        if (wl_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CSUM;
`else
                            hold_ready = 1'b1;
`endif
                        end
                    end
                end
            end

            CSUM: begin
                if (accept) begin
                    state_d = (in_data == csum_q) ? DONE : ERROR;
                end
            end

            DONE, ERROR: begin
                if (restart) begin
                    state_d = LEN0;
                    wl_d    = 16'd0;
                end
            end

            default: begin
                state_d = ERROR;
            end
        endcase

        ready_d     = ((state_d == LEN0) || (state_d == LEN1) ||
                       (state_d == DATA) || (state_d == CSUM)) && !hold_ready;
        done_d      = (state_d == DONE);
        error_d     = (state_d == ERROR);
        cpu_reset_d = (state_d != DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= LEN0;
            len_q        <= 16'd0;
            bcnt_q       <= 2'd0;
            wbuf_q       <= 32'd0;
            csum_q       <= 8'h00;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= 32'd0;
            words_loaded <= 16'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_reset    <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            bcnt_q       <= bcnt_d;
            wbuf_q       <= wbuf_d;
            csum_q       <= csum_d;
            in_ready     <= ready_d;
            imem_we      <= we_d;
            imem_addr    <= addr_d;
            imem_wdata   <= wdata_d;
            words_loaded <= wl_d;
            done         <= done_d;
            error        <= error_d;
            cpu_reset    <= cpu_reset_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: scoreboarded imem writes, handshake and status checks.
// Follows LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        restart = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int cyc = 0;

    logic [39:0] exp_q[$];
    logic [7:0]  stream_q[$];
    logic [31:0] img[$];
    logic [39:0] mon_e;

    imem_boot_loader #(.IMEM_DEPTH(64), .ADDR_W(8)) dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error),
        .words_loaded(words_loaded), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) xfer_cnt <= xfer_cnt + 1;
    end

    // scoreboard: every write must match the head of exp_q, and the core must still be in reset
    always @(negedge clock) begin
        if (reset && imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e) begin
                    errors++;
                    $display("FAIL write: addr=%h data=%h, required addr=%h data=%h",
                             imem_addr, imem_wdata, mon_e[39:32], mon_e[31:0]);
                end
            end
            checks++;
            if (cpu_reset !== 1'b1) begin
                errors++;
                $display("FAIL write_order: cpu_reset=%b during imem_we, required 1", cpu_reset);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic apply_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        in_valid = 1'b0;
        restart = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1 for byte %h", in_ready, b);
            in_valid = 1'b0;
        end else begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_range(input int lo, input int hi, input int max_gap);
        for (int i = lo; i <= hi; i++) begin
            if (max_gap > 0) begin
                int g = $urandom_range(max_gap, 0);
                repeat (g) @(negedge clock);
            end
            send_byte(stream_q[i]);
        end
    endtask

    task automatic send_stream(input int max_gap);
        send_range(0, stream_q.size() - 1, max_gap);
    endtask

    // builds stream_q from img and pushes the expected writes
    task automatic build_stream(input logic bad_csum);
        logic [7:0]  cs;
        logic [31:0] w;
        int n;
        cs = 8'h00;
        n = img.size();
        stream_q.delete();
        stream_q.push_back(8'(n));
        stream_q.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            w = img[i];
            for (int k = 0; k < 4; k++) begin
                stream_q.push_back(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
            exp_q.push_back({8'(i * 4), w});
        end
`ifdef LOADER_CHECKSUM_EN
        stream_q.push_back(cs ^ {7'd0, bad_csum});
`else
        if (bad_csum) stream_q.push_back(8'h00);
`endif
    endtask

    task automatic set_case2();
        img.delete();
        img.push_back(32'h00A00513);
        img.push_back(32'h40B505B3);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done !== 1'b1 && error !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done !== 1'b1 && error !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: done=%b error=%b, required one of them 1", done, error);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes: %0d outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_done(input string name, input logic [15:0] n_words);
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: done=%b cpu_reset=%b error=%b, required 1 0 0",
                     name, done, cpu_reset, error);
        end
        checks++;
        if (words_loaded !== n_words) begin
            errors++;
            $display("FAIL %s_words: words_loaded=%0d, required %0d", name, words_loaded, n_words);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready: in_ready=%b, required 0", name, in_ready);
        end
    endtask

    task automatic pulse_restart_check(input string name);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        checks++;
        if (done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1 ||
            words_loaded !== 16'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: done=%b error=%b cpu_reset=%b words=%0d in_ready=%b, required 0 0 1 0 1",
                     name, done, error, cpu_reset, words_loaded, in_ready);
        end
    endtask

    // tests
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (cpu_reset !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0 ||
            error !== 1'b0 || words_loaded !== 16'd0 || imem_addr !== 8'h00 ||
            imem_wdata !== 32'd0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: cpu_reset=%b in_ready=%b we=%b done=%b error=%b words=%0d addr=%h wdata=%h state=%0d, required 1 0 0 0 0 0 00 0 0",
                     cpu_reset, in_ready, imem_we, done, error, words_loaded, imem_addr, imem_wdata, state_dbg);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 0", in_ready);
        end
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: in_ready=%b, required 1", in_ready);
        end
        repeat (10) @(negedge clock);
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: cpu_reset=%b done=%b, required 1 0", cpu_reset, done);
        end
    endtask

    task automatic test_load();
        int start;
        apply_reset();
        set_case2();
        build_stream(1'b0);
        xfer_cnt = 0;
        start = cyc;
        send_stream(0);
        wait_end(20);
        checks++;
        if (cyc - start !== stream_q.size() + 1) begin
            errors++;
            $display("FAIL back_to_back_latency: %0d cycles, required %0d", cyc - start, stream_q.size() + 1);
        end
        check_done("load", 16'd2);
        check_drained("load");
        checks++;
        if (xfer_cnt !== stream_q.size()) begin
            errors++;
            $display("FAIL load_xfers: %0d, required %0d", xfer_cnt, stream_q.size());
        end
    endtask

    task automatic test_too_long();
        apply_reset();
        stream_q.delete();
        stream_q.push_back(8'h41);
        stream_q.push_back(8'h00);
        send_stream(0);
        repeat (2) @(negedge clock);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL too_long: error=%b in_ready=%b cpu_reset=%b done=%b, required 1 0 1 0",
                     error, in_ready, cpu_reset, done);
        end
        check_drained("too_long");
        pulse_restart_check("restart_from_error");
        img.delete();
        build_stream(1'b0);
        send_stream(0);
        wait_end(20);
        check_done("zero_len", 16'd0);
        check_drained("zero_len");
    endtask

    task automatic test_max_depth();
        apply_reset();
        img.delete();
        for (int i = 0; i < 64; i++)
            img.push_back({8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'(i + 3)});
        build_stream(1'b0);
        send_stream(0);
        wait_end(40);
        check_done("max_depth", 16'd64);
        check_drained("max_depth");
    endtask

    task automatic test_gaps();
        apply_reset();
        set_case2();
        build_stream(1'b0);
        xfer_cnt = 0;
        send_stream(3);
        wait_end(20);
        check_done("gaps", 16'd2);
        check_drained("gaps");
        checks++;
        if (xfer_cnt !== stream_q.size()) begin
            errors++;
            $display("FAIL gaps_xfers: %0d, required %0d", xfer_cnt, stream_q.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_case2();
        build_stream(1'b0);
        exp_q.delete();
        exp_q.push_back({8'h00, 32'h00A00513});
        send_range(0, 6, 0);
        @(negedge clock);
        check_drained("mid_first_word");
        #2 reset = 1'b0;
        #1;
        checks++;
        if (imem_we !== 1'b0 || words_loaded !== 16'd0 || cpu_reset !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: we=%b words=%0d cpu_reset=%b in_ready=%b, required 0 0 1 0",
                     imem_we, words_loaded, cpu_reset, in_ready);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        build_stream(1'b0);
        send_stream(0);
        wait_end(20);
        check_done("after_mid_reset", 16'd2);
        check_drained("after_mid_reset");
    endtask

    task automatic test_restart();
        apply_reset();
        img.delete();
        img.push_back(32'hDEADBEEF);
        img.push_back(32'h12345678);
        img.push_back(32'h0F1E2D3C);
        build_stream(1'b0);
        send_range(0, 5, 0);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        checks++;
        if (words_loaded !== 16'd1 || done !== 1'b0 || error !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL restart_ignored: words=%0d done=%b error=%b cpu_reset=%b, required 1 0 0 1",
                     words_loaded, done, error, cpu_reset);
        end
        send_range(6, stream_q.size() - 1, 0);
        wait_end(20);
        check_done("restart_load", 16'd3);
        check_drained("restart_load");
        pulse_restart_check("restart_from_done");
        set_case2();
        build_stream(1'b0);
        send_stream(1);
        wait_end(20);
        check_done("reload", 16'd2);
        check_drained("reload");
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        apply_reset();
        set_case2();
        build_stream(1'b1);
        send_stream(0);
        wait_end(20);
        checks++;
        if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_csum: error=%b cpu_reset=%b done=%b in_ready=%b, required 1 1 0 0",
                     error, cpu_reset, done, in_ready);
        end
        check_drained("bad_csum");
        pulse_restart_check("restart_after_csum");
        build_stream(1'b0);
        send_stream(0);
        wait_end(20);
        check_done("good_csum", 16'd2);
        check_drained("good_csum");
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_too_long();
        test_max_depth();
        test_gaps();
        test_reset_mid();
        test_restart();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
